ps2_scancode_decoder: RTL and testbench
=======================================

PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset; all state SHALL be in the clk domain.
REQ-002 Port: clk  in  1  system clock; all state updates on rising edge.
REQ-003 Port: rst_n  in  1  asynchronous active-low reset.
REQ-004 Port: ps2_received_data  in  8  scancode byte from the PS/2 receiver, valid only while the strobe is high.
REQ-005 Port: ps2_received_data_strb  in  1  single-cycle strobe; one byte per high cycle.
REQ-006 Port: char_ready  in  1  consumer (Morse encoder) accepts char_data this cycle.
REQ-007 Port: overflow_clr  in  1  synchronous clear of the overflow flag.
REQ-008 Port: char_data  out  8  ASCII code of the FIFO head.
REQ-009 Port: char_valid  out  1  FIFO non-empty; char_data is meaningful.
REQ-010 Port: overflow  out  1  sticky flag: a character was dropped because the FIFO was full.
REQ-011 Parameter: FIFO_DEPTH, default 4, number of buffered characters, power of two.

Function
REQ-012 Decoder FSM SHALL have states IDLE, BREAK, EXT, EXT_BREAK and SHALL advance only on cycles with ps2_received_data_strb=1.
REQ-013 IDLE: byte 0xF0 -> BREAK; 0xE0 -> EXT; any other byte is looked up (REQ-016), stay IDLE.
REQ-014 BREAK: any byte is discarded -> IDLE; EXT: 0xF0 -> EXT_BREAK; 0x5A emits 0x0D -> IDLE; any other byte is discarded -> IDLE.
REQ-015 EXT_BREAK: any byte is discarded -> IDLE.
REQ-016 Lookup (set 2, make codes, always upper case): 1C A, 32 B, 21 C, 23 D, 24 E, 2B F, 34 G, 33 H, 43 I, 3B J, 42 K, 4B L, 3A M, 31 N, 44 O, 4D P, 15 Q, 2D R, 1B S, 2C T, 3C U, 2A V, 1D W, 22 X, 35 Y, 1A Z; 45 0, 16 1, 1E 2, 26 3, 25 4, 2E 5, 36 6, 3D 7, 3E 8, 46 9; 29 space (0x20); 5A 0x0D; 66 0x08; 49 '.'; 41 ','.
REQ-017 Unmapped bytes in IDLE (incl. 0xAA, 0xFA, 0xFE, 0xE1, modifiers) SHALL be discarded without a push or a state change.
REQ-018 Typematic repeats of a make code SHALL each produce one push.
REQ-019 A push SHALL be requested in the strobe cycle; the character SHALL be visible at the FIFO head (if the FIFO was empty) with char_valid=1 on the next cycle (latency 1).
REQ-020 FIFO: first-word-fall-through; char_valid = (count != 0); pop occurs in cycles where char_valid=1 and char_ready=1.
REQ-021 char_ready while char_valid=0 SHALL have no effect; count SHALL never underflow.
REQ-022 Count width is log2(FIFO_DEPTH)+1; read/write pointers wrap modulo FIFO_DEPTH.
REQ-023 A push while count=FIFO_DEPTH and no pop in the same cycle SHALL be dropped and SHALL set overflow=1; FIFO contents unchanged.
REQ-024 A simultaneous push and pop while full SHALL accept the push; count stays FIFO_DEPTH and overflow is not set.
REQ-025 A simultaneous push and pop while empty SHALL NOT pass through in the same cycle; the pop is ignored and count becomes 1.
REQ-026 overflow SHALL remain 1 until overflow_clr=1; if overflow_clr and a new drop occur in the same cycle, overflow SHALL be 1.
REQ-027 FIFO order SHALL be preserved: characters leave in push order.

Reset
REQ-028 While rst_n=0: FSM=IDLE, count=0, pointers=0, overflow=0, char_valid=0, char_data=0x00.
REQ-029 Reset asserted mid-sequence (e.g. after 0xE0 or 0xF0) SHALL discard the partial prefix and all buffered characters.
REQ-030 The first strobe after reset release SHALL be decoded from IDLE.

Verification
REQ-031 Strobes 0x1C, 0xF0, 0x1C -> exactly one char 0x41, char_valid=1 one cycle after the first strobe; the break produces nothing.
REQ-032 Strobes 0xE0, 0x5A, 0xE0, 0xF0, 0x5A -> one char 0x0D; 0xE0 0x75 (arrow key) -> nothing; FSM ends in IDLE.
REQ-033 char_ready=0, strobes 0x16,0x1E,0x26,0x25,0x2E -> FIFO holds 0x31..0x34, overflow=1; drain yields 0x31,0x32,0x33,0x34 in order, then char_valid=0.
REQ-034 FIFO full, char_ready=1 and strobe 0x29 in the same cycle -> head 0x31 popped, 0x20 accepted at tail, overflow stays 0, count=4.
REQ-035 Strobes 0x12 (shift), 0xAA, 0xFA -> no push; then 0xF0 followed by rst_n pulse, then 0x1A -> char 0x5A emitted.
REQ-036 overflow=1, overflow_clr pulse -> overflow=0 next cycle; random byte stream vs. a reference model -> identical character sequence.

Source files
------------

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scancode to ASCII decoder with a small first-word-fall-through
// character FIFO feeding a downstream consumer (Morse encoder).
module ps2_scancode_decoder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ps2_received_data,
    input  logic       ps2_received_data_strb,
    input  logic       char_ready,
    input  logic       overflow_clr,
    output logic [7:0] char_data,
    output logic       char_valid,
    output logic       overflow
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BREAK,
        S_EXT,
        S_EXT_BREAK
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             w_push;
    logic [7:0]       w_push_char;
    logic             w_lut_hit;
    logic [7:0]       w_lut_char;

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic             w_full;
    logic             w_pop;
    logic             w_accept;
    logic             w_drop;

    // Make-code lookup: maps a set-2 make code to upper-case ASCII.
    always_comb begin
        w_lut_hit  = 1'b1;
        w_lut_char = 8'h00;
        case (ps2_received_data)
            8'h1C: w_lut_char = 8'h41;
            8'h32: w_lut_char = 8'h42;
            8'h21: w_lut_char = 8'h43;
            8'h23: w_lut_char = 8'h44;
            8'h24: w_lut_char = 8'h45;
            8'h2B: w_lut_char = 8'h46;
            8'h34: w_lut_char = 8'h47;
            8'h33: w_lut_char = 8'h48;
            8'h43: w_lut_char = 8'h49;
            8'h3B: w_lut_char = 8'h4A;
            8'h42: w_lut_char = 8'h4B;
            8'h4B: w_lut_char = 8'h4C;
            8'h3A: w_lut_char = 8'h4D;
            8'h31: w_lut_char = 8'h4E;
            8'h44: w_lut_char = 8'h4F;
            8'h4D: w_lut_char = 8'h50;
            8'h15: w_lut_char = 8'h51;
            8'h2D: w_lut_char = 8'h52;
            8'h1B: w_lut_char = 8'h53;
            8'h2C: w_lut_char = 8'h54;
            8'h3C: w_lut_char = 8'h55;
            8'h2A: w_lut_char = 8'h56;
            8'h1D: w_lut_char = 8'h57;
            8'h22: w_lut_char = 8'h58;
            8'h35: w_lut_char = 8'h59;
            8'h1A: w_lut_char = 8'h5A;
            8'h45: w_lut_char = 8'h30;
            8'h16: w_lut_char = 8'h31;
            8'h1E: w_lut_char = 8'h32;
            8'h26: w_lut_char = 8'h33;
            8'h25: w_lut_char = 8'h34;
            8'h2E: w_lut_char = 8'h35;
            8'h36: w_lut_char = 8'h36;
            8'h3D: w_lut_char = 8'h37;
            8'h3E: w_lut_char = 8'h38;
            8'h46: w_lut_char = 8'h39;
            8'h29: w_lut_char = 8'h20;
            8'h5A: w_lut_char = 8'h0D;
            8'h66: w_lut_char = 8'h08;
            8'h49: w_lut_char = 8'h2E;
            8'h41: w_lut_char = 8'h2C;
            default: w_lut_hit = 1'b0;
        endcase
    end

    // Decoder state register; reset drops any partially received prefix.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Prefix tracking and push request; only strobe cycles move the FSM.
    always_comb begin
        w_next_state = r_state;
        w_push       = 1'b0;
        w_push_char  = 8'h00;
        if (ps2_received_data_strb) begin
            case (r_state)
                S_IDLE: begin
                    if (ps2_received_data == 8'hF0) begin
                        w_next_state = S_BREAK;
                    end else if (ps2_received_data == 8'hE0) begin
                        w_next_state = S_EXT;
                    end else begin
                        w_push      = w_lut_hit;
                        w_push_char = w_lut_char;
                    end
                end
                S_BREAK: begin
                    w_next_state = S_IDLE;
                end
                S_EXT: begin
                    if (ps2_received_data == 8'hF0) begin
                        w_next_state = S_EXT_BREAK;
                    end else begin
                        w_next_state = S_IDLE;
                        if (ps2_received_data == 8'h5A) begin
                            w_push      = 1'b1;
                            w_push_char = 8'h0D;
                        end
                    end
                end
                S_EXT_BREAK: begin
                    w_next_state = S_IDLE;
                end
                default: begin
                    w_next_state = S_IDLE;
                end
            endcase
        end
    end

    // A full FIFO still takes a push when the head leaves in the same cycle;
    // an empty FIFO never passes a push straight through to the consumer.
    always_comb begin
        w_full   = (r_count == FULL_COUNT);
        w_pop    = char_valid && char_ready;
        w_accept = w_push && (!w_full || w_pop);
        w_drop   = w_push && w_full && !w_pop;
    end

    // Character storage; contents are masked at the output while empty.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= w_push_char;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky drop flag; a fresh drop wins over a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (overflow_clr) begin
            r_overflow <= 1'b0;
        end
    end

    // Output view of the FIFO head.
    always_comb begin
        char_valid = (r_count != '0);
        char_data  = char_valid ? r_mem[r_rd_ptr] : 8'h00;
        overflow   = r_overflow;
    end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Self-checking bench for ps2_scancode_decoder: directed vector table,
// hand-written FIFO/reset sequences and a random stream against a model.
module tb_ps2_scancode_decoder;

    logic       clk;
    logic       rst_n;
    logic [7:0] ps2_received_data;
    logic       ps2_received_data_strb;
    logic       char_ready;
    logic       overflow_clr;
    logic [7:0] char_data;
    logic       char_valid;
    logic       overflow;

    int totalChecks = 0;
    int passedChecks = 0;

    typedef struct {
        logic [7:0] code;
        bit         expPush;
        logic [7:0] expChar;
    } vec_t;

    vec_t vecs[$];

    byte unsigned codeList [41] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
        8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
        8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A, 8'h45, 8'h16, 8'h1E, 8'h26,
        8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h29, 8'h5A, 8'h66, 8'h49,
        8'h41};
    byte unsigned charList [41] = '{
        8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49, 8'h4A,
        8'h4B, 8'h4C, 8'h4D, 8'h4E, 8'h4F, 8'h50, 8'h51, 8'h52, 8'h53, 8'h54,
        8'h55, 8'h56, 8'h57, 8'h58, 8'h59, 8'h5A, 8'h30, 8'h31, 8'h32, 8'h33,
        8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h20, 8'h0D, 8'h08, 8'h2E,
        8'h2C};

    logic [8:0]  lut [256];
    logic [7:0]  modelQ[$];
    int          modelState;

    ps2_scancode_decoder #(.FIFO_DEPTH(4)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .ps2_received_data      (ps2_received_data),
        .ps2_received_data_strb (ps2_received_data_strb),
        .char_ready             (char_ready),
        .overflow_clr           (overflow_clr),
        .char_data              (char_data),
        .char_valid             (char_valid),
        .overflow               (overflow)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        totalChecks++;
        if (act === exp) begin
            passedChecks++;
        end else begin
            $display("[TB] FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] code);
        ps2_received_data      = code;
        ps2_received_data_strb = 1'b1;
        tick();
        ps2_received_data_strb = 1'b0;
        ps2_received_data      = 8'h00;
    endtask

    task automatic pulseReset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Reference decoder: 0=idle 1=break 2=ext 3=ext-break.
    task automatic modelDecode(input logic [7:0] code, output bit emit, output logic [7:0] ch);
        emit = 1'b0;
        ch   = 8'h00;
        if (modelState == 0) begin
            if (code == 8'hF0) modelState = 1;
            else if (code == 8'hE0) modelState = 2;
            else if (lut[code][8]) begin
                emit = 1'b1;
                ch   = lut[code][7:0];
            end
        end else if (modelState == 2) begin
            if (code == 8'hF0) modelState = 3;
            else begin
                modelState = 0;
                if (code == 8'h5A) begin
                    emit = 1'b1;
                    ch   = 8'h0D;
                end
            end
        end else begin
            modelState = 0;
        end
    endtask

    initial begin
        logic [7:0] expSeq [4];
        bit         emit;
        logic [7:0] ch;
        logic [7:0] code;
        bit         pop;

        for (int i = 0; i < 256; i++) lut[i] = 9'h000;
        for (int i = 0; i < 41; i++) lut[codeList[i]] = {1'b1, charList[i]};

        vecs.push_back('{8'h1C, 1'b1, 8'h41});
        vecs.push_back('{8'hF0, 1'b0, 8'h00});
        vecs.push_back('{8'h1C, 1'b0, 8'h00});
        vecs.push_back('{8'h32, 1'b1, 8'h42});
        vecs.push_back('{8'h45, 1'b1, 8'h30});
        vecs.push_back('{8'h46, 1'b1, 8'h39});
        vecs.push_back('{8'h29, 1'b1, 8'h20});
        vecs.push_back('{8'h5A, 1'b1, 8'h0D});
        vecs.push_back('{8'h66, 1'b1, 8'h08});
        vecs.push_back('{8'h49, 1'b1, 8'h2E});
        vecs.push_back('{8'h41, 1'b1, 8'h2C});
        vecs.push_back('{8'h1A, 1'b1, 8'h5A});
        vecs.push_back('{8'hE0, 1'b0, 8'h00});
        vecs.push_back('{8'h5A, 1'b1, 8'h0D});
        vecs.push_back('{8'hE0, 1'b0, 8'h00});
        vecs.push_back('{8'hF0, 1'b0, 8'h00});
        vecs.push_back('{8'h5A, 1'b0, 8'h00});
        vecs.push_back('{8'hE0, 1'b0, 8'h00});
        vecs.push_back('{8'h75, 1'b0, 8'h00});
        vecs.push_back('{8'h12, 1'b0, 8'h00});
        vecs.push_back('{8'hAA, 1'b0, 8'h00});
        vecs.push_back('{8'hFA, 1'b0, 8'h00});
        vecs.push_back('{8'hE1, 1'b0, 8'h00});
        vecs.push_back('{8'h1C, 1'b1, 8'h41});
        vecs.push_back('{8'h1C, 1'b1, 8'h41});
        vecs.push_back('{8'hE0, 1'b0, 8'h00});
        vecs.push_back('{8'hF0, 1'b0, 8'h00});
        vecs.push_back('{8'h1C, 1'b0, 8'h00});
        vecs.push_back('{8'h15, 1'b1, 8'h51});
        vecs.push_back('{8'h4D, 1'b1, 8'h50});
        vecs.push_back('{8'hF0, 1'b0, 8'h00});
        vecs.push_back('{8'hE0, 1'b0, 8'h00});
        vecs.push_back('{8'h2C, 1'b1, 8'h54});

        rst_n                  = 1'b0;
        ps2_received_data      = 8'h00;
        ps2_received_data_strb = 1'b0;
        char_ready             = 1'b0;
        overflow_clr           = 1'b0;
        tick();
        tick();
        checkOutput("reset_valid", {7'b0, char_valid}, 8'h00);
        checkOutput("reset_data", char_data, 8'h00);
        checkOutput("reset_overflow", {7'b0, overflow}, 8'h00);
        rst_n = 1'b1;
        tick();

        // Table-driven decode: consumer always ready, one strobe then one idle.
        char_ready = 1'b1;
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].code);
            checkOutput($sformatf("vec%0d_valid", i), {7'b0, char_valid}, {7'b0, vecs[i].expPush});
            if (vecs[i].expPush) begin
                checkOutput($sformatf("vec%0d_data", i), char_data, vecs[i].expChar);
            end
            tick();
            checkOutput($sformatf("vec%0d_drained", i), {7'b0, char_valid}, 8'h00);
        end

        // Fill past capacity with consumer stalled.
        char_ready = 1'b0;
        applyStimulus(8'h16);
        applyStimulus(8'h1E);
        applyStimulus(8'h26);
        applyStimulus(8'h25);
        checkOutput("full_no_overflow", {7'b0, overflow}, 8'h00);
        applyStimulus(8'h2E);
        checkOutput("overflow_set", {7'b0, overflow}, 8'h01);
        expSeq = '{8'h31, 8'h32, 8'h33, 8'h34};
        char_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("drain%0d", i), char_data, expSeq[i]);
            tick();
        end
        char_ready = 1'b0;
        checkOutput("drain_empty", {7'b0, char_valid}, 8'h00);
        checkOutput("overflow_sticky", {7'b0, overflow}, 8'h01);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        checkOutput("overflow_cleared", {7'b0, overflow}, 8'h00);

        // Push and pop together while full.
        applyStimulus(8'h16);
        applyStimulus(8'h1E);
        applyStimulus(8'h26);
        applyStimulus(8'h25);
        char_ready = 1'b1;
        applyStimulus(8'h29);
        char_ready = 1'b0;
        checkOutput("fullpp_overflow", {7'b0, overflow}, 8'h00);
        checkOutput("fullpp_head", char_data, 8'h32);
        // Still full: a drop together with a clear leaves the flag set.
        overflow_clr = 1'b1;
        applyStimulus(8'h1C);
        overflow_clr = 1'b0;
        checkOutput("drop_beats_clear", {7'b0, overflow}, 8'h01);
        expSeq = '{8'h32, 8'h33, 8'h34, 8'h20};
        char_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("drain_pp%0d", i), char_data, expSeq[i]);
            tick();
        end
        checkOutput("drain_pp_empty", {7'b0, char_valid}, 8'h00);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;

        // Reset in the middle of a break prefix with a buffered character.
        char_ready = 1'b0;
        applyStimulus(8'h1C);
        applyStimulus(8'hF0);
        pulseReset();
        checkOutput("rst_flush_valid", {7'b0, char_valid}, 8'h00);
        applyStimulus(8'h1A);
        checkOutput("rst_break_valid", {7'b0, char_valid}, 8'h01);
        checkOutput("rst_break_data", char_data, 8'h5A);
        pulseReset();
        applyStimulus(8'hE0);
        pulseReset();
        applyStimulus(8'h1C);
        checkOutput("rst_ext_data", char_data, 8'h41);
        pulseReset();

        // Random stream against the reference model.
        modelState = 0;
        modelQ.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            char_ready             = 1'($urandom_range(0, 1));
            ps2_received_data_strb = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0:       code = 8'hF0;
                1:       code = 8'hE0;
                2:       code = 8'($urandom_range(0, 255));
                default: code = codeList[$urandom_range(0, 40)];
            endcase
            ps2_received_data = code;
            checkOutput($sformatf("rnd%0d_valid", cyc), {7'b0, char_valid},
                        {7'b0, (modelQ.size() != 0)});
            if (modelQ.size() != 0) begin
                checkOutput($sformatf("rnd%0d_data", cyc), char_data, modelQ[0]);
            end
            pop = (modelQ.size() != 0) && char_ready;
            emit = 1'b0;
            ch   = 8'h00;
            if (ps2_received_data_strb) modelDecode(code, emit, ch);
            if (pop) void'(modelQ.pop_front());
            if (emit && modelQ.size() < 4) modelQ.push_back(ch);
            tick();
        end
        ps2_received_data_strb = 1'b0;
        char_ready             = 1'b0;

        $display("%0d/%0d checks passed", passedChecks, totalChecks);
        $finish;
    end

endmodule
